// File: rtl/write_seq_driver_if.sv
// ============================================================================
// Module      : write_seq_driver_if
// Description : Bundles the request/data side and the bitline drive side of
//               the SRAM write sequencer.
//               master : requester (drives req/data_in/mask_in)
//               slave  : write_seq_driver (drives ready/done/bitline outputs)
//   req      - write request, qualified by ready
//   data_in  - write data, 1 = store 1 (bl high, blb low)
//   mask_in  - per-column write enable, 1 = column written
//   ready    - request accepted on this edge if req = 1
//   done     - single-cycle completion pulse
//   bl_wr    - true-bitline drive level
//   blb_wr   - complement-bitline drive level
//   drv_en   - per-column driver enable, 0 = column not driven
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface write_seq_driver_if #(
  parameter int COLS = 8
);
  logic            req;
  logic [COLS-1:0] data_in;
  logic [COLS-1:0] mask_in;
  logic            ready;
  logic            done;
  logic [COLS-1:0] bl_wr;
  logic [COLS-1:0] blb_wr;
  logic [COLS-1:0] drv_en;

  modport master (
    output req, data_in, mask_in,
    input  ready, done, bl_wr, blb_wr, drv_en
  );

  modport slave (
    input  req, data_in, mask_in,
    output ready, done, bl_wr, blb_wr, drv_en
  );
endinterface

`default_nettype wire

// File: rtl/write_seq_driver.sv
// ============================================================================
// Module      : write_seq_driver
// Description : SRAM write-driver sequencer. On an accepted request the
//               captured data is settled on the bitlines (SETUP), the
//               masked column drivers are enabled (DRIVE), then bitlines are
//               returned to precharge (RECOVER) before a done pulse in IDLE.
// Ports       :
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - write_seq_driver_if.slave (req/data_in/mask_in in,
//          ready/done/bl_wr/blb_wr/drv_en out, all outputs registered)
// Parameters  : COLS, SETUP_CYC (1..15), PULSE_CYC (1..15), REC_CYC (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module write_seq_driver #(
  parameter int COLS      = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int REC_CYC   = 1
) (
  input wire                 clk,
  input wire                 rst,
  write_seq_driver_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_DRIVE   = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  // Phase counter is loaded with (length - 1) on state entry and counts down
  // to zero, so every phase length 1..15 fits in 4 bits without wrapping.
  localparam logic [3:0] C_SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] C_PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] C_REC_LD   = 4'(REC_CYC - 1);

  state_t          r_state, w_state_next;
  logic [3:0]      r_phase, w_phase_next;
  logic [COLS-1:0] r_data,  w_data_next;
  logic [COLS-1:0] r_mask,  w_mask_next;

  logic            r_ready, w_ready_next;
  logic            r_done,  w_done_next;
  logic [COLS-1:0] r_bl,    w_bl_next;
  logic [COLS-1:0] r_blb,   w_blb_next;
  logic [COLS-1:0] r_en,    w_en_next;

  // Next-state, phase counter and capture logic
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_data_next  = r_data;
    w_mask_next  = r_mask;
    w_done_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          w_state_next = S_SETUP;
          w_phase_next = C_SETUP_LD;
          w_data_next  = bus.data_in;
          w_mask_next  = bus.mask_in;
        end
      end
      S_SETUP: begin
        if (r_phase == 4'd0) begin
          w_state_next = S_DRIVE;
          w_phase_next = C_PULSE_LD;
        end else begin
          w_phase_next = r_phase - 4'd1;
        end
      end
      S_DRIVE: begin
        if (r_phase == 4'd0) begin
          w_state_next = S_RECOVER;
          w_phase_next = C_REC_LD;
        end else begin
          w_phase_next = r_phase - 4'd1;
        end
      end
      S_RECOVER: begin
        if (r_phase == 4'd0) begin
          w_state_next = S_IDLE;
          w_phase_next = 4'd0;
          w_done_next  = 1'b1;
        end else begin
          w_phase_next = r_phase - 4'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_phase_next = 4'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so outputs come straight from
  // flops and line up with the state they describe.
  always_comb begin
    w_ready_next = 1'b0;
    w_bl_next    = '1;
    w_blb_next   = '1;
    w_en_next    = '0;

    case (w_state_next)
      S_IDLE: begin
        w_ready_next = 1'b1;
      end
      S_SETUP: begin
        w_bl_next  = w_data_next;
        w_blb_next = ~w_data_next;
      end
      S_DRIVE: begin
        // bl/blb are complementary here, so an enabled column never sees
        // equal levels on both bitlines.
        w_bl_next  = w_data_next;
        w_blb_next = ~w_data_next;
        w_en_next  = w_mask_next;
      end
      default: begin
        // RECOVER: precharge level, drivers off
        w_bl_next  = '1;
        w_blb_next = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_phase <= 4'd0;
      r_data  <= '0;
      r_mask  <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_bl    <= '1;
      r_blb   <= '1;
      r_en    <= '0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_data  <= w_data_next;
      r_mask  <= w_mask_next;
      r_ready <= w_ready_next;
      r_done  <= w_done_next;
      r_bl    <= w_bl_next;
      r_blb   <= w_blb_next;
      r_en    <= w_en_next;
    end
  end

  assign bus.ready  = r_ready;
  assign bus.done   = r_done;
  assign bus.bl_wr  = r_bl;
  assign bus.blb_wr = r_blb;
  assign bus.drv_en = r_en;

endmodule

`default_nettype wire

// File: tb/tb_write_seq_driver.sv
// ============================================================================
// Module      : tb_write_seq_driver
// Description : Self-checking bench for write_seq_driver. A timeline model
//               derives every cycle's expected outputs from the offset since
//               the last accepted request; table vectors, hand sequences for
//               back-to-back/busy/reset cases and random traffic drive it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_write_seq_driver;

  localparam int COLS = 8;
  localparam int S    = 1;
  localparam int P    = 2;
  localparam int R    = 1;
  localparam int L    = S + P + R + 1;   // accept edge to done cycle

  logic clk = 1'b0;
  logic rst;

  write_seq_driver_if #(.COLS(COLS)) bus ();

  write_seq_driver #(
    .COLS      (COLS),
    .SETUP_CYC (S),
    .PULSE_CYC (P),
    .REC_CYC   (R)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycle count, cycle of the last accept, capture
  int       cyc      = 0;
  int       acc      = 0;
  bit       have_txn = 1'b0;
  logic [7:0] m_data = '0;
  logic [7:0] m_mask = '0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] mask;
    logic [7:0] exp_bl;
    logic [7:0] exp_blb;
    logic [7:0] exp_en;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, update the model with what the DUT saw at that edge,
  // then compare every output against the model.
  task automatic tick();
    int         off;
    logic       e_rdy, e_done;
    logic [7:0] e_bl, e_blb, e_en;
    @(posedge clk);
    if (rst) begin
      have_txn = 1'b0;
      m_data   = '0;
      m_mask   = '0;
    end else if ((!have_txn || (cyc - acc) >= L) && bus.req) begin
      have_txn = 1'b1;
      acc      = cyc;
      m_data   = bus.data_in;
      m_mask   = bus.mask_in;
    end
    cyc++;
    off    = cyc - acc;
    e_rdy  = 1'b1;
    e_done = 1'b0;
    e_bl   = '1;
    e_blb  = '1;
    e_en   = '0;
    if (have_txn) begin
      if (off <= S) begin
        e_rdy = 1'b0; e_bl = m_data; e_blb = ~m_data;
      end else if (off <= S + P) begin
        e_rdy = 1'b0; e_bl = m_data; e_blb = ~m_data; e_en = m_mask;
      end else if (off <= S + P + R) begin
        e_rdy = 1'b0;
      end else if (off == L) begin
        e_done = 1'b1;
      end
    end
    #1;
    check("ready",  32'(bus.ready),  32'(e_rdy));
    check("done",   32'(bus.done),   32'(e_done));
    check("bl_wr",  32'(bus.bl_wr),  32'(e_bl));
    check("blb_wr", 32'(bus.blb_wr), 32'(e_blb));
    check("drv_en", 32'(bus.drv_en), 32'(e_en));
    check("en_with_equal_bitlines", 32'(bus.drv_en & ~(bus.bl_wr ^ bus.blb_wr)), 32'd0);
  endtask

  initial begin
    int dones;

    vecs[0] = '{8'hA5, 8'hFF, 8'hA5, 8'h5A, 8'hFF};
    vecs[1] = '{8'h3C, 8'h0F, 8'h3C, 8'hC3, 8'h0F};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
    vecs[3] = '{8'h00, 8'hAA, 8'h00, 8'hFF, 8'hAA};
    vecs[4] = '{8'h5A, 8'hF0, 8'h5A, 8'hA5, 8'hF0};
    vecs[5] = '{8'h81, 8'h3C, 8'h81, 8'h7E, 8'h3C};

    rst         = 1'b1;
    bus.req     = 1'b0;
    bus.data_in = 8'h00;
    bus.mask_in = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_bl",    32'(bus.bl_wr), 32'hFF);
    tick();

    // Table-driven single transactions, inputs scrambled while busy
    for (int i = 0; i < 6; i++) begin
      bus.req = 1'b1; bus.data_in = vecs[i].data; bus.mask_in = vecs[i].mask;
      tick();                                   // accept edge, c1 visible
      bus.req = 1'b0; bus.data_in = 8'($urandom); bus.mask_in = 8'($urandom);
      check("vec_setup_bl", 32'(bus.bl_wr),  32'(vecs[i].exp_bl));
      check("vec_setup_en", 32'(bus.drv_en), 32'd0);
      tick();                                   // c2
      check("vec_drive_bl",  32'(bus.bl_wr),  32'(vecs[i].exp_bl));
      check("vec_drive_blb", 32'(bus.blb_wr), 32'(vecs[i].exp_blb));
      check("vec_drive_en",  32'(bus.drv_en), 32'(vecs[i].exp_en));
      tick();                                   // c3
      check("vec_drive2_en", 32'(bus.drv_en), 32'(vecs[i].exp_en));
      tick();                                   // c4 recover
      check("vec_rec_bl", 32'(bus.bl_wr), 32'hFF);
      check("vec_rec_en", 32'(bus.drv_en), 32'd0);
      tick();                                   // c5 done
      check("vec_done_c5",  32'(bus.done),  32'd1);
      check("vec_ready_c5", 32'(bus.ready), 32'd1);
      tick();
      check("vec_done_single", 32'(bus.done), 32'd0);
    end

    // Back-to-back: req held high, second accepted on the done cycle
    bus.req = 1'b1; bus.data_in = 8'h01; bus.mask_in = 8'hFF;
    tick();                                     // accept 0x01, c1
    bus.data_in = 8'h80;
    for (int k = 2; k <= 10; k++) begin
      tick();
      if (k == 5 || k == 10) check("b2b_done", 32'(bus.done), 32'd1);
      if (k == 7) check("b2b_second_bl", 32'(bus.bl_wr), 32'h80);
      if (k == 6) bus.req = 1'b0;
    end
    tick();

    // Requests while busy are ignored: exactly one done
    dones = 0;
    bus.req = 1'b1; bus.data_in = 8'h55; bus.mask_in = 8'h33;
    tick();
    for (int k = 1; k <= 12; k++) begin
      bus.req = (k <= 3);
      bus.data_in = 8'($urandom);
      tick();
      if (bus.done) dones++;
    end
    check("busy_one_done", 32'(dones), 32'd1);

    // Reset during DRIVE aborts without done
    bus.req = 1'b1; bus.data_in = 8'hC3; bus.mask_in = 8'hFF;
    tick();                                     // c1
    bus.req = 1'b0;
    tick();                                     // c2 drive
    check("rst_pre_en", 32'(bus.drv_en), 32'hFF);
    rst = 1'b1;
    tick();                                     // c3
    rst = 1'b0;
    check("rst_abort_en", 32'(bus.drv_en), 32'd0);
    check("rst_abort_bl", 32'(bus.bl_wr), 32'hFF);
    check("rst_abort_ready", 32'(bus.ready), 32'd1);
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.done) dones++;
    end
    check("rst_no_done", 32'(dones), 32'd0);

    // Reset wins over a simultaneous request
    rst = 1'b1; bus.req = 1'b1;
    tick();
    rst = 1'b0; bus.req = 1'b0;
    check("rst_prio_ready", 32'(bus.ready), 32'd1);
    tick();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      bus.req     = ($urandom_range(0, 1) == 1);
      bus.data_in = 8'($urandom);
      bus.mask_in = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rst         = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0; bus.req = 1'b0;
    for (int k = 0; k < 8; k++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/write_seq_driver.md
WRITE_SEQ_DRIVER -- requirements
Module: write_seq_driver

Interface
REQ-001 SHALL have parameter COLS, default 8: number of bitline column pairs.
REQ-002 SHALL have parameter SETUP_CYC, default 1: cycles bitline data is settled before drive, legal range 1..15.
REQ-003 SHALL have parameter PULSE_CYC, default 2: cycles of active write drive, legal range 1..15.
REQ-004 SHALL have parameter REC_CYC, default 1: recovery cycles after drive, legal range 1..15.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port req, input, 1: write request, qualified by ready.
REQ-008 SHALL have port data_in, input, COLS: write data, 1 = store 1 (bl high, blb low).
REQ-009 SHALL have port mask_in, input, COLS: per-column write enable, 1 = column written.
REQ-010 SHALL have port ready, output, 1: request accepted on this edge if req=1.
REQ-011 SHALL have port done, output, 1: single-cycle completion pulse.
REQ-012 SHALL have port bl_wr, output, COLS: true-bitline drive level.
REQ-013 SHALL have port blb_wr, output, COLS: complement-bitline drive level.
REQ-014 SHALL have port drv_en, output, COLS: per-column driver enable, 0 = column not driven.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, DRIVE, RECOVER, all outputs registered.
REQ-016 SHALL assert ready only in IDLE.
REQ-017 SHALL, in IDLE with req=1, capture data_in and mask_in and enter SETUP on that edge.
REQ-018 SHALL ignore req and input changes outside IDLE, with the captured data held until the next accept.
REQ-019 SHALL, in SETUP, drive bl_wr=data, blb_wr=~data, drv_en=0 for exactly SETUP_CYC cycles, then enter DRIVE.
REQ-020 SHALL, in DRIVE, keep bl_wr/blb_wr and set drv_en=mask for exactly PULSE_CYC cycles, then enter RECOVER.
REQ-021 SHALL, in RECOVER, set drv_en=0 and bl_wr=blb_wr=all ones (precharge level) for exactly REC_CYC cycles, then enter IDLE.
REQ-022 SHALL, in IDLE, output bl_wr=blb_wr=all ones and drv_en=0.
REQ-023 SHALL assert done for exactly the first IDLE cycle following RECOVER, concurrent with ready=1.
REQ-024 SHALL give latency from the accept edge to done high of SETUP_CYC+PULSE_CYC+REC_CYC+1 cycles.
REQ-025 SHALL accept a new req in the same cycle done=1 (back-to-back, no bubble beyond REQ-024).
REQ-026 SHALL never assert drv_en[i] with bl_wr[i]==blb_wr[i].
REQ-027 SHALL, with mask all zero, run the full sequence with drv_en=0 throughout and still pulse done.
REQ-028 SHALL use a single phase counter of 4 bits, reloaded on each state entry, with no wrap-around.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, enter IDLE: ready=1, done=0, drv_en=0, bl_wr=blb_wr=all ones, captured data/mask=0.
REQ-030 SHALL, on rst mid-operation, abort the sequence without a done pulse, and drv_en=0 from the following cycle.
REQ-031 SHALL give rst priority over a simultaneous req, which is dropped.

Verification (COLS=8, SETUP_CYC=1, PULSE_CYC=2, REC_CYC=1)
REQ-032 SHALL cover: req at edge 0, data 0xA5, mask 0xFF -> c1 bl=A5 blb=5A en=00; c2-c3 en=FF; c4 RECOVER en=00 bl=blb=FF; c5 done=1 ready=1.
REQ-033 SHALL cover: data 0x3C, mask 0x0F -> during DRIVE en=0F, bl=3C, blb=C3; done at c5.
REQ-034 SHALL cover: req held high continuously with data 0x01 then 0x80 -> second accepted at the done cycle (c5), its done at c10.
REQ-035 SHALL cover: req at c1, c2, c3 while busy -> ignored, exactly one done.
REQ-036 SHALL cover: rst asserted during DRIVE (c2) -> c3 IDLE, en=00, bl=blb=FF, no done in following 10 cycles.
REQ-037 SHALL cover: mask 0x00, data 0xFF -> en=00 all cycles, done at c5.
